am25ls_piso_shifter: RTL and testbench

//  Parallel-in/serial-out shifter that reads back a word held by an nDFF register stage.
//  It is the outbound end of that register's parallel-capture path: it latches a parallel

---
 rtl/am25ls_piso_shifter_pkg.sv | 15 +
 rtl/am25ls_piso_shifter_bitcnt.sv | 30 +++
 rtl/am25ls_piso_shifter.sv | 99 +++++++++
 tb/tb_am25ls_piso_shifter.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/am25ls_piso_shifter_pkg.sv
// Shared definitions for the PISO shifter: FSM encodings and counter width.
package am25ls_piso_shifter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    // Bits needed to hold WIDTH-1; never less than one bit.
    function automatic int cnt_w(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/am25ls_piso_shifter_bitcnt.sv
// Loadable down-counter that tracks the remaining bits of the word in flight.
module am25ls_bitcnt #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             clr_,
    input  logic             ld,
    input  logic [CNT_W-1:0] ld_val,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_reg;

    // Saturates at zero so a stray enable never wraps the count.
    always_ff @(posedge clk or negedge clr_) begin
        if (!clr_) begin
            cnt_reg <= '0;
        end else if (ld) begin
            cnt_reg <= ld_val;
        end else if (en && (cnt_reg != '0)) begin
            cnt_reg <= cnt_reg - 1'b1;
        end
    end

    assign cnt  = cnt_reg;
    assign zero = (cnt_reg == '0);

endmodule

// File: rtl/am25ls_piso_shifter.sv
// Parallel-in/serial-out shifter with held complementary copy of the loaded word.
module am25ls_piso_shifter
    import am25ls_piso_shifter_pkg::*;
#(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             clr_,
    input  logic [WIDTH-1:0] d,
    input  logic             load_,
    input  logic             msb_first,
    output logic             ser_out,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_
);

    localparam int CNT_W = cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state_reg;
    state_t           state_next;
    logic [WIDTH-1:0] sr_reg;
    logic [WIDTH-1:0] q_reg;
    logic             dir_reg;
    logic [CNT_W-1:0] cnt;
    logic             cnt_zero;
    logic             load_accept;

    // Loads are honoured only when no word is in flight.
    assign load_accept = !load_ && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));

    am25ls_bitcnt #(
        .CNT_W (CNT_W)
    ) u_bitcnt (
        .clk    (clk),
        .clr_   (clr_),
        .ld     (load_accept),
        .ld_val (LAST_BIT),
        .en     (state_reg == ST_SHIFT),
        .cnt    (cnt),
        .zero   (cnt_zero)
    );

    always_ff @(posedge clk or negedge clr_) begin
        if (!clr_) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = ST_IDLE;
        case (state_reg)
            ST_IDLE:  state_next = load_ ? ST_IDLE : ST_SHIFT;
            ST_SHIFT: state_next = cnt_zero ? ST_DONE : ST_SHIFT;
            ST_DONE:  state_next = load_ ? ST_IDLE : ST_SHIFT;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_reg)
            ST_SHIFT: busy = 1'b1;
            ST_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    // Shift register is flushed on the final bit so ser_out idles low.
    always_ff @(posedge clk or negedge clr_) begin
        if (!clr_) begin
            sr_reg  <= '0;
            q_reg   <= '0;
            dir_reg <= 1'b0;
        end else if (load_accept) begin
            sr_reg  <= d;
            q_reg   <= d;
            dir_reg <= msb_first;
        end else if (state_reg == ST_SHIFT) begin
            if (cnt_zero) begin
                sr_reg <= '0;
            end else if (dir_reg) begin
                sr_reg <= sr_reg << 1;
            end else begin
                sr_reg <= sr_reg >> 1;
            end
        end
    end

    assign ser_out = dir_reg ? sr_reg[WIDTH-1] : sr_reg[0];
    assign q       = q_reg;
    assign q_      = ~q_reg;

endmodule

// File: tb/tb_am25ls_piso_shifter.sv
// Directed bench for am25ls_piso_shifter at WIDTH=6.
module tb_am25ls_piso_shifter;

    localparam int W = 6;

    logic         clk;
    logic         clr_;
    logic [W-1:0] d;
    logic         load_;
    logic         msb_first;
    logic         ser_out;
    logic         busy;
    logic         done;
    logic [W-1:0] q;
    logic [W-1:0] q_;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string        tag;
        logic         load_n;
        logic         msb;
        logic [W-1:0] din;
        logic         exp_ser;
        logic         exp_busy;
        logic         exp_done;
        logic [W-1:0] exp_q;
    } vec_t;

    vec_t vecs[$];

    am25ls_piso_shifter #(.WIDTH(W)) dut (
        .clk       (clk),
        .clr_      (clr_),
        .d         (d),
        .load_     (load_),
        .msb_first (msb_first),
        .ser_out   (ser_out),
        .busy      (busy),
        .done      (done),
        .q         (q),
        .q_        (q_)
    );

    initial begin
        clk = 1'bx;
        #3 clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string name, input logic es, input logic eb,
                           input logic ed, input logic [W-1:0] eq);
        chk({name, ".ser"},  {5'b0, ser_out}, {5'b0, es});
        chk({name, ".busy"}, {5'b0, busy},    {5'b0, eb});
        chk({name, ".done"}, {5'b0, done},    {5'b0, ed});
        chk({name, ".q"},    q,  eq);
        chk({name, ".q_"},   q_, ~eq);
    endtask

    task automatic show(input string tag);
        $display("t=%0t %s d=%b clr_=%b clk=%b ser=%b busy=%b done=%b q=%b q_=%b",
                 $time, tag, d, clr_, clk, ser_out, busy, done, q, q_);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(string tag, logic ln, logic m, logic [W-1:0] di,
                                logic es, logic eb, logic ed, logic [W-1:0] eq);
        vec_t v;
        v.tag = tag; v.load_n = ln; v.msb = m; v.din = di;
        v.exp_ser = es; v.exp_busy = eb; v.exp_done = ed; v.exp_q = eq;
        return v;
    endfunction

    initial begin
        // MSB first: 101100 -> 1,0,1,1,0,0
        vecs.push_back(mk("msb.load", 0, 1, 6'b101100, 1, 1, 0, 6'b101100));
        vecs.push_back(mk("msb.b1",   1, 1, 6'b000000, 0, 1, 0, 6'b101100));
        vecs.push_back(mk("msb.b2",   1, 1, 6'b000000, 1, 1, 0, 6'b101100));
        vecs.push_back(mk("msb.b3",   1, 1, 6'b000000, 1, 1, 0, 6'b101100));
        vecs.push_back(mk("msb.b4",   1, 1, 6'b000000, 0, 1, 0, 6'b101100));
        vecs.push_back(mk("msb.b5",   1, 1, 6'b000000, 0, 1, 0, 6'b101100));
        vecs.push_back(mk("msb.done", 1, 1, 6'b000000, 0, 0, 1, 6'b101100));
        vecs.push_back(mk("msb.idle", 1, 1, 6'b000000, 0, 0, 0, 6'b101100));
        vecs.push_back(mk("msb.hold", 1, 0, 6'b111000, 0, 0, 0, 6'b101100));
        // LSB first: 101100 -> 0,0,1,1,0,1 with msb_first toggling mid-word
        vecs.push_back(mk("lsb.load", 0, 0, 6'b101100, 0, 1, 0, 6'b101100));
        vecs.push_back(mk("lsb.b1",   1, 1, 6'b000000, 0, 1, 0, 6'b101100));
        vecs.push_back(mk("lsb.b2",   1, 0, 6'b000000, 1, 1, 0, 6'b101100));
        vecs.push_back(mk("lsb.b3",   1, 1, 6'b000000, 1, 1, 0, 6'b101100));
        vecs.push_back(mk("lsb.b4",   1, 1, 6'b000000, 0, 1, 0, 6'b101100));
        vecs.push_back(mk("lsb.b5",   1, 0, 6'b000000, 1, 1, 0, 6'b101100));
        vecs.push_back(mk("lsb.done", 1, 0, 6'b000000, 0, 0, 1, 6'b101100));
        vecs.push_back(mk("lsb.idle", 1, 0, 6'b000000, 0, 0, 0, 6'b101100));
        // Load during shift is ignored
        vecs.push_back(mk("ign.load", 0, 1, 6'b111111, 1, 1, 0, 6'b111111));
        vecs.push_back(mk("ign.b1",   1, 1, 6'b000000, 1, 1, 0, 6'b111111));
        vecs.push_back(mk("ign.b2",   0, 1, 6'b000000, 1, 1, 0, 6'b111111));
        vecs.push_back(mk("ign.b3",   0, 0, 6'b000000, 1, 1, 0, 6'b111111));
        vecs.push_back(mk("ign.b4",   1, 1, 6'b000000, 1, 1, 0, 6'b111111));
        vecs.push_back(mk("ign.b5",   1, 1, 6'b000000, 1, 1, 0, 6'b111111));
        vecs.push_back(mk("ign.done", 1, 1, 6'b000000, 0, 0, 1, 6'b111111));
        vecs.push_back(mk("ign.idle", 1, 1, 6'b000000, 0, 0, 0, 6'b111111));
        // Back-to-back: 010101 MSB first, reload 101010 from DONE
        vecs.push_back(mk("b2b.load", 0, 1, 6'b010101, 0, 1, 0, 6'b010101));
        vecs.push_back(mk("b2b.b1",   1, 1, 6'b000000, 1, 1, 0, 6'b010101));
        vecs.push_back(mk("b2b.b2",   1, 1, 6'b000000, 0, 1, 0, 6'b010101));
        vecs.push_back(mk("b2b.b3",   1, 1, 6'b000000, 1, 1, 0, 6'b010101));
        vecs.push_back(mk("b2b.b4",   1, 1, 6'b000000, 0, 1, 0, 6'b010101));
        vecs.push_back(mk("b2b.b5",   0, 1, 6'b101010, 1, 1, 0, 6'b010101));
        vecs.push_back(mk("b2b.done", 0, 1, 6'b101010, 0, 0, 1, 6'b010101));
        vecs.push_back(mk("b2b.ld2",  0, 1, 6'b101010, 1, 1, 0, 6'b101010));
        vecs.push_back(mk("b2b.c1",   1, 1, 6'b000000, 0, 1, 0, 6'b101010));
        vecs.push_back(mk("b2b.c2",   1, 1, 6'b000000, 1, 1, 0, 6'b101010));
        vecs.push_back(mk("b2b.c3",   1, 1, 6'b000000, 0, 1, 0, 6'b101010));
        vecs.push_back(mk("b2b.c4",   1, 1, 6'b000000, 1, 1, 0, 6'b101010));
        vecs.push_back(mk("b2b.c5",   1, 1, 6'b000000, 0, 1, 0, 6'b101010));
        vecs.push_back(mk("b2b.done", 1, 1, 6'b000000, 0, 0, 1, 6'b101010));
        vecs.push_back(mk("b2b.idle", 1, 1, 6'b000000, 0, 0, 0, 6'b101010));

        // Clear with undriven data and clock
        clr_ = 1'b0; d = 'x; load_ = 1'b1; msb_first = 1'b0;
        #1;
        show("clear");
        chk_all("clear", 0, 0, 0, 6'b000000);
        d = 6'b111111; load_ = 1'b0; msb_first = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            show("clear.clk");
            chk_all("clear.held", 0, 0, 0, 6'b000000);
        end
        load_ = 1'b1;
        #2 clr_ = 1'b1;
        tick();
        show("release");
        chk_all("release", 0, 0, 0, 6'b000000);

        foreach (vecs[i]) begin
            d = vecs[i].din; load_ = vecs[i].load_n; msb_first = vecs[i].msb;
            tick();
            show(vecs[i].tag);
            chk_all(vecs[i].tag, vecs[i].exp_ser, vecs[i].exp_busy,
                    vecs[i].exp_done, vecs[i].exp_q);
        end

        // Abort: 110011 MSB first, clear while bit 3 is on ser_out
        d = 6'b110011; load_ = 1'b0; msb_first = 1'b1;
        tick(); show("abort.load"); chk_all("abort.b0", 1, 1, 0, 6'b110011);
        load_ = 1'b1;
        tick(); show("abort.b1");   chk_all("abort.b1", 1, 1, 0, 6'b110011);
        tick(); show("abort.b2");   chk_all("abort.b2", 0, 1, 0, 6'b110011);
        #2 clr_ = 1'b0;
        #1 show("abort.clr");       chk_all("abort.clr", 0, 0, 0, 6'b000000);
        for (int i = 0; i < 6; i++) begin
            tick();
            show("abort.held");
            chk_all("abort.nodone", 0, 0, 0, 6'b000000);
        end
        #2 clr_ = 1'b1;
        tick(); show("abort.rel");  chk_all("abort.rel", 0, 0, 0, 6'b000000);

        // 000111 LSB first -> 1,1,1,0,0,0
        d = 6'b000111; load_ = 1'b0; msb_first = 1'b0;
        begin
            logic [W-1:0] bits;
            bits = 6'b111000;
            for (int i = 0; i < W; i++) begin
                tick();
                load_ = 1'b1; msb_first = 1'b1;
                show("post.bit");
                chk_all("post.bit", bits[W-1-i], 1, 0, 6'b000111);
            end
        end
        tick(); show("post.done"); chk_all("post.done", 0, 0, 1, 6'b000111);
        tick(); show("post.idle"); chk_all("post.idle", 0, 0, 0, 6'b000111);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
